fifo_sync_param: RTL and testbench
==================================

FIFO_SYNC_PARAM -- requirements
Module: fifo_sync_param

Interface
REQ-001 SHALL have parameter DATA_W, default 9, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 8, number of entries (power of two, >=2).
REQ-003 SHALL have parameter AFULL_TH, default DEPTH-2, count at or above which almost_full asserts.
REQ-004 SHALL have parameter AEMPTY_TH, default 2, count at or below which almost_empty asserts.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port clr  input  1  synchronous flush of pointers and count.
REQ-008 SHALL have port wr_en  input  1  write request.
REQ-009 SHALL have port wr_data  input  DATA_W  write data.
REQ-010 SHALL have port rd_en  input  1  read request.
REQ-011 SHALL have port rd_data  output  DATA_W  registered read data.
REQ-012 SHALL have port rd_valid  output  1  rd_data updated this cycle.
REQ-013 SHALL have port full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-015 SHALL have port overflow, underflow  output  1 each  one-cycle error pulses.

Function
REQ-016 SHALL hold storage as DEPTH x DATA_W array with write and read pointers of $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0 naturally.
REQ-017 SHALL accept a write when wr_en && (!full || rd_accept); accepted write stores wr_data at wr pointer and increments it.
REQ-018 SHALL accept a read (rd_accept) when rd_en && !empty; no fall-through: a write to an empty FIFO is not readable in the same cycle.
REQ-019 SHALL load rd_data with the entry at rd pointer on the edge where a read is accepted and assert rd_valid for exactly the following cycle (1-cycle latency); rd_data holds its value otherwise (never driven to Z).
REQ-020 SHALL update count: +1 write only, -1 read only, unchanged for both or neither; count never exceeds DEPTH nor goes below 0.
REQ-021 SHALL set full = (count==DEPTH), empty = (count==0), almost_full = (count>=AFULL_TH), almost_empty = (count<=AEMPTY_TH), all derived from registered count.
REQ-022 SHALL, when full and wr_en and rd_en both high, accept both; count stays DEPTH, no overflow.
REQ-023 SHALL pulse overflow for one cycle when wr_en high, full high and no read accepted; write discarded, state unchanged.
REQ-024 SHALL pulse underflow for one cycle when rd_en high and empty high; rd_data unchanged, rd_valid low.
REQ-025 SHALL, when clr high, zero both pointers and count on that edge, ignore wr_en/rd_en, and suppress rd_valid, overflow and underflow; array contents not cleared; clr has priority over all requests.

Reset
REQ-026 SHALL, on rst high, immediately (asynchronously) force pointers=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0; hence empty=1, full=0, almost_empty=1, almost_full=(AFULL_TH==0).
REQ-027 SHALL ignore all inputs while rst high; reset asserted mid-transfer discards all buffered data; operation resumes on first rising edge after rst deasserts.

Verification
REQ-028 Defaults; rst pulse, then write 9'h001..9'h008 on 8 cycles -> full=1 and count=8 after 8th edge, almost_full=1 from count=6; 9th write -> overflow pulse, count stays 8.
REQ-029 From full, 8 consecutive reads -> rd_data 9'h001..9'h008 in order, each with rd_valid one cycle after rd_en; empty=1 after last; 9th read -> underflow pulse, rd_data stays 9'h008.
REQ-030 Wrap: write 5, read 5, write 8 (9'h100..9'h107), read 8 -> data returned in order across pointer wrap, count returns to 0.
REQ-031 Simultaneous: at full, wr_en=rd_en=1 with 9'h1FF -> count stays 8, no overflow, 9'h1FF returned last; at empty, wr_en=rd_en=1 -> count=1, underflow pulse, rd_valid=0.
REQ-032 clr with count=5 and wr_en=rd_en=1 -> next cycle count=0, empty=1, no rd_valid/overflow/underflow; rst asserted mid-burst -> flags reset without clock edge.
REQ-033 Re-run REQ-028..030 with DATA_W=16, DEPTH=32, AFULL_TH=30, AEMPTY_TH=4 -> same ordering, flag thresholds at 30/4, count reaches 32.

Source files
------------

// File: rtl/fifo_sync_param.sv
// Synchronous single-clock FIFO with registered read port, occupancy count,
// threshold flags and one-cycle overflow/underflow error pulses.
module fifo_sync_param #(
  parameter int unsigned DATA_W    = 9,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AFULL_TH  = DEPTH - 2,
  parameter int unsigned AEMPTY_TH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              wr_acc_c, rd_acc_c;

  // Status flags come straight from the registered occupancy.
  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (32'(count_q) >= AFULL_TH);
  assign almost_empty = (32'(count_q) <= AEMPTY_TH);

  assign count     = count_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  // A read frees a slot in the same cycle, so a write to a full FIFO is
  // accepted when paired with a read.
  assign rd_acc_c = rd_en && !empty;
  assign wr_acc_c = wr_en && (!full || rd_acc_c);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc_c) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_acc_c) begin
        rd_data_d  = mem_q[rd_ptr_q];
        rd_ptr_d   = rd_ptr_q + AW'(1);
        rd_valid_d = 1'b1;
      end
      if (wr_acc_c && !rd_acc_c) begin
        count_d = count_q + CW'(1);
      end else if (rd_acc_c && !wr_acc_c) begin
        count_d = count_q - CW'(1);
      end
      overflow_d  = wr_en && full && !rd_acc_c;
      underflow_d = rd_en && empty;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; a flush or reset only rewinds the pointers.
  always_ff @(posedge clk) begin
    if (!rst && !clr && wr_acc_c) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Randomized and directed bench for fifo_sync_param in two configurations,
// checked against a queue-based reference model.
module tb_fifo_sync_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        wr, rd, clr;
  logic [15:0] wd;

  logic [8:0]  rd_data0;
  logic        rd_valid0, full0, empty0, afull0, aempty0, ovf0, unf0;
  logic [3:0]  count0;
  logic [15:0] rd_data1;
  logic        rd_valid1, full1, empty1, afull1, aempty1, ovf1, unf1;
  logic [5:0]  count1;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int          q[$];
  int          m_last;
  logic        m_valid, m_ovf, m_unf;

  always #5 clk = ~clk;

  fifo_sync_param u_dut0 (
    .clk(clk), .rst(rst), .clr(clr & ~sel),
    .wr_en(wr & ~sel), .wr_data(wd[8:0]), .rd_en(rd & ~sel),
    .rd_data(rd_data0), .rd_valid(rd_valid0),
    .full(full0), .empty(empty0), .almost_full(afull0), .almost_empty(aempty0),
    .count(count0), .overflow(ovf0), .underflow(unf0)
  );

  fifo_sync_param #(.DATA_W(16), .DEPTH(32), .AFULL_TH(30), .AEMPTY_TH(4)) u_dut1 (
    .clk(clk), .rst(rst), .clr(clr & sel),
    .wr_en(wr & sel), .wr_data(wd), .rd_en(rd & sel),
    .rd_data(rd_data1), .rd_valid(rd_valid1),
    .full(full1), .empty(empty1), .almost_full(afull1), .almost_empty(aempty1),
    .count(count1), .overflow(ovf1), .underflow(unf1)
  );

  function automatic int depth();
    return sel ? 32 : 8;
  endfunction

  function automatic int afull_th();
    return sel ? 30 : 6;
  endfunction

  function automatic int aempty_th();
    return sel ? 4 : 2;
  endfunction

  function automatic logic [15:0] dmask();
    return sel ? 16'hFFFF : 16'h01FF;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s cfg=%0d t=%0t: got %0h expected %0h", tag, sel, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_last  = 0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  task automatic model_step(input logic w, input int d, input logic r, input logic c);
    bit rd_ok, wr_ok;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    if (c) begin
      q.delete();
    end else begin
      rd_ok = r && (q.size() > 0);
      wr_ok = w && ((q.size() < depth()) || rd_ok);
      m_ovf = w && (q.size() == depth()) && !rd_ok;
      m_unf = r && (q.size() == 0);
      if (rd_ok) begin
        m_last  = q.pop_front();
        m_valid = 1'b1;
      end
      if (wr_ok) q.push_back(d);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    check("count",        sel ? int'(count1)   : int'(count0),   n);
    check("full",         sel ? int'(full1)    : int'(full0),    int'(n == depth()));
    check("empty",        sel ? int'(empty1)   : int'(empty0),   int'(n == 0));
    check("almost_full",  sel ? int'(afull1)   : int'(afull0),   int'(n >= afull_th()));
    check("almost_empty", sel ? int'(aempty1)  : int'(aempty0),  int'(n <= aempty_th()));
    check("rd_valid",     sel ? int'(rd_valid1): int'(rd_valid0),int'(m_valid));
    check("overflow",     sel ? int'(ovf1)     : int'(ovf0),     int'(m_ovf));
    check("underflow",    sel ? int'(unf1)     : int'(unf0),     int'(m_unf));
    check("rd_data",      sel ? int'(rd_data1) : int'(rd_data0), m_last);
  endtask

  task automatic cyc(input logic w, input logic [15:0] d, input logic r, input logic c);
    logic [15:0] dm;
    dm  = d & dmask();
    wr  = w;
    wd  = dm;
    rd  = r;
    clr = c;
    @(posedge clk);
    model_step(w, int'(dm), r, c);
    #1;
    check_all();
    wr  = 1'b0;
    rd  = 1'b0;
    clr = 1'b0;
  endtask

  // Asserts reset between edges; flags must respond before any clock edge.
  task automatic do_reset();
    wr  = 1'b1;
    rd  = 1'b1;
    wd  = 16'h0055;
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
    wr  = 1'b0;
    rd  = 1'b0;
  endtask

  task automatic run_config();
    int d;
    d = depth();
    do_reset();
    // Fill, then one write too many
    for (int i = 1; i <= d; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0);
    cyc(1'b1, 16'h0AA, 1'b0, 1'b0);
    // Drain, then one read too many
    for (int i = 0; i < d; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    // Pointer wrap
    for (int i = 0; i < 5; i++) cyc(1'b1, 16'(16'h0020 + i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0);
    for (int i = 0; i < d; i++) cyc(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0);
    for (int i = 0; i < d; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0);
    // Simultaneous read/write at full, then at empty
    for (int i = 0; i < d; i++) cyc(1'b1, 16'(16'h0040 + i), 1'b0, 1'b0);
    cyc(1'b1, 16'h01FF, 1'b1, 1'b0);
    for (int i = 0; i < d; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0);
    cyc(1'b1, 16'h0033, 1'b1, 1'b0);
    // Flush with requests pending
    for (int i = 0; i < 4; i++) cyc(1'b1, 16'(16'h0060 + i), 1'b0, 1'b0);
    cyc(1'b1, 16'h0077, 1'b1, 1'b1);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    // Randomized traffic with shifting read/write bias
    for (int i = 0; i < 400; i++) begin
      int bias;
      bias = ((i / 40) % 2 == 0) ? 75 : 25;
      cyc(($urandom_range(99) < bias) ? 1'b1 : 1'b0, 16'($urandom()),
          ($urandom_range(99) >= bias) ? 1'b1 : 1'b0,
          ($urandom_range(63) == 0) ? 1'b1 : 1'b0);
    end
    // Reset in the middle of a burst
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'($urandom()), 1'b0, 1'b0);
    do_reset();
    cyc(1'b1, 16'h0011, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    sel = 1'b0;
    wr  = 1'b0;
    rd  = 1'b0;
    clr = 1'b0;
    wd  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run_config();
    sel = 1'b1;
    run_config();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
